// File: rtl/hazard_sched_unit.sv
// Hazard scheduler for the 5-stage RV32I core: forwarding selects,
// load-use / memory-freeze stalls, branch flushes and a stall counter.
module hazard_sched_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic [4:0]       rd_ID,
  input  logic             rs1use_ID,
  input  logic             rs2use_ID,
  input  logic [1:0]       optype_ID,
  input  logic             Branch_ID,
  input  logic             mem_busy,
  output logic [1:0]       fwd_A,
  output logic [1:0]       fwd_B,
  output logic             fwd_ls,
  output logic             stall_PC,
  output logic             stall_IFID,
  output logic             stall_pipe,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_ALU   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_STORE = 2'd3
  } op_e;

  logic [4:0]       rd_ex_q, rd_ex_d;
  logic [4:0]       rd_mem_q, rd_mem_d;
  op_e              op_ex_q, op_ex_d;
  op_e              op_mem_q, op_mem_d;
  logic             fwd_ls_q, fwd_ls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  op_e  op_id;
  logic a_ex, a_mem, b_ex, b_mem;
  logic load_use, ld_st;

  assign op_id = op_e'(optype_ID);

  // Only ALU and LOAD ops write rd; x0 is never a real destination.
  function automatic logic hit(
    input logic [4:0] rs,
    input logic       en,
    input logic [4:0] rd,
    input op_e        op
  );
    return en && (rs != 5'd0) && (rs == rd) &&
           ((op == OP_ALU) || (op == OP_LOAD));
  endfunction

  always_comb begin
    a_ex  = hit(rs1_ID, rs1use_ID, rd_ex_q, op_ex_q);
    a_mem = hit(rs1_ID, rs1use_ID, rd_mem_q, op_mem_q);
    b_ex  = hit(rs2_ID, rs2use_ID, rd_ex_q, op_ex_q);
    b_mem = hit(rs2_ID, rs2use_ID, rd_mem_q, op_mem_q);

    if (a_ex && op_ex_q == OP_ALU)        fwd_A = 2'd1;
    else if (a_mem && op_mem_q == OP_ALU) fwd_A = 2'd2;
    else if (a_mem)                       fwd_A = 2'd3;
    else                                  fwd_A = 2'd0;

    if (b_ex && op_ex_q == OP_ALU)        fwd_B = 2'd1;
    else if (b_mem && op_mem_q == OP_ALU) fwd_B = 2'd2;
    else if (b_mem)                       fwd_B = 2'd3;
    else                                  fwd_B = 2'd0;

    load_use = (op_ex_q == OP_LOAD) &&
               (a_ex || (b_ex && op_id != OP_STORE));
    ld_st    = (op_ex_q == OP_LOAD) && b_ex &&
               (op_id == OP_STORE) && !a_ex;
  end

  always_comb begin
    stall_PC   = 1'b0;
    stall_IFID = 1'b0;
    stall_pipe = 1'b0;
    flush_IFID = 1'b0;
    flush_IDEX = 1'b0;
    rd_ex_d    = rd_ex_q;
    op_ex_d    = op_ex_q;
    rd_mem_d   = rd_mem_q;
    op_mem_d   = op_mem_q;
    fwd_ls_d   = fwd_ls_q;

    if (!rst_n) begin
      stall_PC = 1'b0;
    end else if (mem_busy) begin
      stall_PC   = 1'b1;
      stall_IFID = 1'b1;
      stall_pipe = 1'b1;
    end else if (load_use) begin
      // Branch operands are not ready yet, so the branch waits too.
      stall_PC   = 1'b1;
      stall_IFID = 1'b1;
      flush_IDEX = 1'b1;
      rd_mem_d   = rd_ex_q;
      op_mem_d   = op_ex_q;
      rd_ex_d    = 5'd0;
      op_ex_d    = OP_NONE;
      fwd_ls_d   = 1'b0;
    end else begin
      flush_IFID = Branch_ID;
      rd_mem_d   = rd_ex_q;
      op_mem_d   = op_ex_q;
      rd_ex_d    = rd_ID;
      op_ex_d    = op_id;
      fwd_ls_d   = ld_st;
    end

    cnt_d = cnt_q;
    if (stall_PC && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ex_q  <= 5'd0;
      op_ex_q  <= OP_NONE;
      rd_mem_q <= 5'd0;
      op_mem_q <= OP_NONE;
      fwd_ls_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rd_ex_q  <= rd_ex_d;
      op_ex_q  <= op_ex_d;
      rd_mem_q <= rd_mem_d;
      op_mem_q <= op_mem_d;
      fwd_ls_q <= fwd_ls_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fwd_ls    = fwd_ls_q;
  assign stall_cnt = cnt_q;

endmodule
